share_mem_client: RTL and testbench

Initiator for the shared single-read/single-write memory (one write port, one read port whose address is picked by a select between two address inputs, one-cycle registered read data). It takes writes from one client and reads from two clients, arbitrates the read port, tracks the read in flight, forwards same-cycle write data, and returns tagged responses through a 2-entry buffered response channel with backpressure. It sits between the datapath clients and the memory instance.

---
 rtl/share_mem_pkg.sv | 18 +
 rtl/share_mem_rsp_fifo.sv | 59 +++++
 rtl/share_mem_client.sv | 138 +++++++++++++
 tb/tb_share_mem_client.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/share_mem_pkg.sv
// Shared types and constants for the shared-memory client.
//   RdId_t         - reader identifier (reader 0 or reader 1)
//   RdRsp_t        - tagged read response {id, data}
//   RSP_FIFO_DEPTH - number of buffered responses
//   RSP_DATA_W     - response data width (matches the client's N)
package share_mem_pkg;

  localparam int RSP_FIFO_DEPTH = 2;
  localparam int RSP_DATA_W     = 4;

  typedef logic RdId_t;

  typedef struct packed {
    RdId_t                 id;
    logic [RSP_DATA_W-1:0] data;
  } RdRsp_t;

endpackage

// File: rtl/share_mem_rsp_fifo.sv
// Two-entry response FIFO for the shared-memory client.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   push        - write push_data into the tail
//   push_data   - response to enqueue
//   pop         - drop the head entry
//   head        - current head entry (registered storage)
//   full, empty - occupancy flags
//   count       - number of stored entries (0..2)
module share_mem_rsp_fifo
  import share_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  RdRsp_t     push_data,
  input  logic       pop,
  output RdRsp_t     head,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  RdRsp_t     store_r [RSP_FIFO_DEPTH];
  logic       rd_ptr_r;
  logic       wr_ptr_r;
  logic [1:0] count_r;

  // Storage, pointers and occupancy; depth 2 so each pointer is a single toggling bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
        store_r[i] <= '0;
      end
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        store_r[wr_ptr_r] <= push_data;
        wr_ptr_r          <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = store_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);

endmodule

// File: rtl/share_mem_client.sv
// Initiator for the shared single-read/single-write memory.
// One write client is passed straight to the memory write port; two read
// clients share the read port under round-robin arbitration with a credit
// check against the response buffer. Read data comes back one cycle after the
// grant, is forwarded from a same-cycle write where needed, and is queued as a
// tagged response with backpressure.
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   IN_wrValid/IN_wrAddr/IN_wrData  - write request
//   IN_rdValid[1:0]                 - read requests (bit r = reader r)
//   IN_rdAddr0/IN_rdAddr1           - read addresses
//   OUT_rdReady[1:0]                - one-hot read grant
//   IN_rspReady                     - response consumer ready
//   OUT_rspValid/OUT_rspId/OUT_rspData - response channel
//   OUT_memWe/OUT_memWAddr/OUT_memWData - memory write port
//   OUT_memSel                      - 1 selects OUT_memRAddrB, 0 selects OUT_memRAddrC
//   OUT_memRAddrB/OUT_memRAddrC     - memory read addresses
//   IN_memRData                     - memory read data (one cycle after address)
module share_mem_client
  import share_mem_pkg::*;
#(
  parameter int N  = RSP_DATA_W,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          IN_wrValid,
  input  logic [AW-1:0] IN_wrAddr,
  input  logic [N-1:0]  IN_wrData,
  input  logic [1:0]    IN_rdValid,
  input  logic [AW-1:0] IN_rdAddr0,
  input  logic [AW-1:0] IN_rdAddr1,
  output logic [1:0]    OUT_rdReady,
  input  logic          IN_rspReady,
  output logic          OUT_rspValid,
  output logic          OUT_rspId,
  output logic [N-1:0]  OUT_rspData,
  output logic          OUT_memWe,
  output logic [AW-1:0] OUT_memWAddr,
  output logic [N-1:0]  OUT_memWData,
  output logic          OUT_memSel,
  output logic [AW-1:0] OUT_memRAddrB,
  output logic [AW-1:0] OUT_memRAddrC,
  input  logic [N-1:0]  IN_memRData
);

  logic          rr_r;
  logic          infl_valid_r;
  RdId_t         infl_id_r;
  logic          infl_fwd_r;
  logic [N-1:0]  infl_fwd_data_r;

  logic [1:0]    grant_s;
  logic [1:0]    pending_s;
  logic          credit_s;
  logic          pop_s;
  logic          fwd_s;
  logic [AW-1:0] gnt_addr_s;
  logic [1:0]    fifo_count_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  RdRsp_t        push_rsp_s;
  RdRsp_t        head_s;

  assign pop_s = ~fifo_empty_s & IN_rspReady;

  // Responses still owed after this cycle's pop; at most 2 may be owed at once.
  // Pop only happens when non-empty, so the subtraction never underflows.
  assign pending_s = fifo_count_s - {1'b0, pop_s} + {1'b0, infl_valid_r};
  assign credit_s  = (pending_s < 2'd2);

  // Round-robin grant: a lone requester wins outright, rr_r breaks ties.
  always_comb begin
    grant_s = 2'b00;
    if (rst || !credit_s) begin
      grant_s = 2'b00;
    end else begin
      case (IN_rdValid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = rr_r ? 2'b10 : 2'b01;
        default: grant_s = 2'b00;
      endcase
    end
  end

  // The memory returns pre-write data, so a same-cycle write to the granted
  // address must be captured and substituted when the read returns.
  assign gnt_addr_s = grant_s[0] ? IN_rdAddr0 : IN_rdAddr1;
  assign fwd_s      = IN_wrValid && (IN_wrAddr == gnt_addr_s);

  // Arbitration pointer and in-flight read tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_r            <= 1'b0;
      infl_valid_r    <= 1'b0;
      infl_id_r       <= 1'b0;
      infl_fwd_r      <= 1'b0;
      infl_fwd_data_r <= '0;
    end else begin
      infl_valid_r <= |grant_s;
      if (|grant_s) begin
        rr_r            <= grant_s[0];
        infl_id_r       <= grant_s[1];
        infl_fwd_r      <= fwd_s;
        infl_fwd_data_r <= IN_wrData;
      end
    end
  end

  assign push_rsp_s.id   = infl_id_r;
  assign push_rsp_s.data = infl_fwd_r ? infl_fwd_data_r : IN_memRData;

  share_mem_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (infl_valid_r),
    .push_data (push_rsp_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign OUT_rdReady   = grant_s;
  assign OUT_rspValid  = ~fifo_empty_s;
  assign OUT_rspId     = head_s.id;
  assign OUT_rspData   = head_s.data;

  assign OUT_memWe     = IN_wrValid;
  assign OUT_memWAddr  = IN_wrAddr;
  assign OUT_memWData  = IN_wrData;
  assign OUT_memSel    = grant_s[0];
  assign OUT_memRAddrB = IN_rdAddr0;
  assign OUT_memRAddrC = IN_rdAddr1;

endmodule

// File: tb/tb_share_mem_client.sv
// Self-checking bench for share_mem_client: includes a behavioural memory,
// a reference model of outstanding responses (queue of expected {id, data,
// first-visible cycle}) and a shadow copy of memory contents.
module tb_share_mem_client;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic [1:0] rd_valid;
  logic [3:0] rd_addr0;
  logic [3:0] rd_addr1;
  logic [1:0] rd_ready;
  logic       rsp_ready;
  logic       rsp_valid;
  logic       rsp_id;
  logic [3:0] rsp_data;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [3:0] mem_wdata;
  logic       mem_sel;
  logic [3:0] mem_raddr_b;
  logic [3:0] mem_raddr_c;
  logic [3:0] mem_rdata;

  typedef struct {
    logic       id;
    logic [3:0] data;
    int         vis;
  } exp_t;

  logic [3:0] mem     [16];
  logic [3:0] ref_mem [16];
  exp_t       sb [$];
  int         rr_m;
  int         cyc;
  int         checks;
  int         errors;
  logic [1:0] last_grant;

  always #5 clk = ~clk;

  share_mem_client dut (
    .clk           (clk),
    .rst           (rst),
    .IN_wrValid    (wr_valid),
    .IN_wrAddr     (wr_addr),
    .IN_wrData     (wr_data),
    .IN_rdValid    (rd_valid),
    .IN_rdAddr0    (rd_addr0),
    .IN_rdAddr1    (rd_addr1),
    .OUT_rdReady   (rd_ready),
    .IN_rspReady   (rsp_ready),
    .OUT_rspValid  (rsp_valid),
    .OUT_rspId     (rsp_id),
    .OUT_rspData   (rsp_data),
    .OUT_memWe     (mem_we),
    .OUT_memWAddr  (mem_waddr),
    .OUT_memWData  (mem_wdata),
    .OUT_memSel    (mem_sel),
    .OUT_memRAddrB (mem_raddr_b),
    .OUT_memRAddrC (mem_raddr_c),
    .IN_memRData   (mem_rdata)
  );

  // Behavioural memory: registered read of pre-write contents, selected address.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_sel ? mem_raddr_b : mem_raddr_c];
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // One clock cycle: drive inputs, compare against the model, advance model and clock.
  task automatic step(input logic wv, input logic [3:0] wa, input logic [3:0] wd,
                      input logic [1:0] rv, input logic [3:0] a0, input logic [3:0] a1,
                      input logic rdy);
    logic       exp_valid;
    logic       pop;
    int         owed;
    logic [1:0] eg;
    logic [3:0] ga;
    exp_t       e;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr0 = a0; rd_addr1 = a1; rsp_ready = rdy;
    #1;
    exp_valid = (sb.size() > 0) && (sb[0].vis <= cyc);
    checks++;
    if (rsp_valid !== exp_valid) begin
      errors++;
      $display("FAIL rspValid cyc=%0d got %b exp %b", cyc, rsp_valid, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if (rsp_id !== sb[0].id || rsp_data !== sb[0].data) begin
        errors++;
        $display("FAIL rsp_payload cyc=%0d got id=%b data=%h exp id=%b data=%h",
                 cyc, rsp_id, rsp_data, sb[0].id, sb[0].data);
      end
    end
    pop  = exp_valid && rdy;
    owed = sb.size() - (pop ? 1 : 0);
    eg   = 2'b00;
    if (owed < 2) begin
      if (rv == 2'b11) eg = (rr_m == 0) ? 2'b01 : 2'b10;
      else             eg = rv;
    end
    checks++;
    if (rd_ready !== eg || mem_sel !== eg[0]) begin
      errors++;
      $display("FAIL grant cyc=%0d got rdReady=%b sel=%b exp rdReady=%b sel=%b",
               cyc, rd_ready, mem_sel, eg, eg[0]);
    end
    checks++;
    if (mem_we !== wv || mem_waddr !== wa || mem_wdata !== wd ||
        mem_raddr_b !== a0 || mem_raddr_c !== a1) begin
      errors++;
      $display("FAIL mem_port cyc=%0d got we=%b wa=%h wd=%h b=%h c=%h exp we=%b wa=%h wd=%h b=%h c=%h",
               cyc, mem_we, mem_waddr, mem_wdata, mem_raddr_b, mem_raddr_c, wv, wa, wd, a0, a1);
    end
    last_grant = rd_ready;
    if (pop) void'(sb.pop_front());
    if (eg != 2'b00) begin
      ga     = eg[0] ? a0 : a1;
      e.id   = eg[1];
      e.data = (wv && wa == ga) ? wd : ref_mem[ga];
      e.vis  = cyc + 2;
      sb.push_back(e);
      rr_m   = eg[0] ? 1 : 0;
    end
    if (wv) ref_mem[wa] = wd;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 2'b00, 4'h0, 4'h0, 1'b1);
  endtask

  task automatic do_reset();
    wr_valid = 1'b0; rd_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    rr_m = 0;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_valid = 1'b0; wr_addr = 4'h2; wr_data = 4'h9;
    rd_valid = 2'b11; rd_addr0 = 4'h6; rd_addr1 = 4'hB; rsp_ready = 1'b1;
    #2;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 4'h0 || rd_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b id=%b data=%h ready=%b exp 0 0 0 00",
               rsp_valid, rsp_id, rsp_data, rd_ready);
    end
    checks++;
    if (mem_raddr_b !== 4'h6 || mem_raddr_c !== 4'hB || mem_we !== 1'b0 || mem_waddr !== 4'h2) begin
      errors++;
      $display("FAIL reset_mem_port got b=%h c=%h we=%b wa=%h exp 6 b 0 2",
               mem_raddr_b, mem_raddr_c, mem_we, mem_waddr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    rr_m = 0;
    cyc = 0;
  endtask

  task automatic test_write_then_read();
    step(1'b1, 4'h3, 4'h5, 2'b00, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 2'b01, 4'h3, 4'h0, 1'b1);
    checks++;
    if (last_grant !== 2'b01) begin
      errors++;
      $display("FAIL wr_rd_grant got %b exp 01", last_grant);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_early got %b exp 0", rsp_valid);
    end
    step(1'b0, 4'h0, 4'h0, 2'b00, 4'h0, 4'h0, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 4'h5) begin
      errors++;
      $display("FAIL wr_rd_rsp got v=%b id=%b d=%h exp 1 0 5", rsp_valid, rsp_id, rsp_data);
    end
    idle(2);
  endtask

  task automatic test_forward();
    step(1'b1, 4'h7, 4'hA, 2'b10, 4'h0, 4'h7, 1'b1);
    checks++;
    if (last_grant !== 2'b10) begin
      errors++;
      $display("FAIL fwd_grant got %b exp 10", last_grant);
    end
    step(1'b0, 4'h0, 4'h0, 2'b00, 4'h0, 4'h0, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 4'hA) begin
      errors++;
      $display("FAIL fwd_rsp got v=%b id=%b d=%h exp 1 1 a", rsp_valid, rsp_id, rsp_data);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'h0, 4'h0, 2'b11, 4'h3, 4'h7, 1'b1);
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (last_grant !== want) begin
        errors++;
        $display("FAIL b2b_grant i=%0d got %b exp %b", i, last_grant, want);
      end
    end
    idle(3);
  endtask

  task automatic test_backpressure();
    int grants;
    grants = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'h0, 4'h0, 2'b11, 4'h3, 4'h7, 1'b0);
      if (last_grant != 2'b00) grants++;
    end
    checks++;
    if (grants !== 2 || last_grant !== 2'b00) begin
      errors++;
      $display("FAIL bp_grants got %0d last=%b exp 2 last=00", grants, last_grant);
    end
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'h0, 4'h0, 2'b11, 4'h3, 4'h7, 1'b1);
      if (last_grant != 2'b00) grants++;
    end
    checks++;
    if (grants !== 6) begin
      errors++;
      $display("FAIL bp_resume got %0d grants exp 6", grants);
    end
    idle(3);
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] want;
    step(1'b0, 4'h0, 4'h0, 2'b01, 4'h3, 4'h0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 2'b10, 4'h0, 4'h5, 1'b0);
    rd_valid = 2'b11;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rd_ready !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid got valid=%b ready=%b exp 0 00", rsp_valid, rd_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    rr_m = 0;
    cyc++;
    idle(3);
    want = ref_mem[4'h3];
    step(1'b0, 4'h0, 4'h0, 2'b01, 4'h3, 4'h0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 2'b00, 4'h0, 4'h0, 1'b0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== want) begin
      errors++;
      $display("FAIL rst_first_read got v=%b id=%b d=%h exp 1 0 %h", rsp_valid, rsp_id, rsp_data, want);
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 4'($urandom),
           2'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0));
    end
    idle(4);
  endtask

  initial begin
    checks = 0; errors = 0; rr_m = 0; cyc = 0; last_grant = 2'b00;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 4'h0;
      ref_mem[i] = 4'h0;
    end
    test_reset();
    test_write_then_read();
    test_forward();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
